qick_xcom_exec: RTL and testbench

// Parametrised command executor for the XCOM link. Takes local commands (4-phase req/ack) and

---
 rtl/qick_xcom_exec.sv | 256 +++++++++++++++++++++++++
 tb/tb_qick_xcom_exec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qick_xcom_exec.sv
// XCOM command executor: local 4-phase commands take priority over a FIFO of received
// network commands; both update flag, data registers, memory and board ID, plus auto-ID.
module qick_xcom_exec #(
    parameter int DW         = 32,
    parameter int NREG       = 2,
    parameter int MEM_DEPTH  = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_CYC    = 65535
) (
    input  logic                        c_clk_i,
    input  logic                        c_rst_i,
    input  logic                        cmd_loc_req_i,
    output logic                        cmd_loc_ack_o,
    input  logic [7:0]                  cmd_loc_op_i,
    input  logic [DW-1:0]               cmd_loc_dt_i,
    input  logic                        rx_cmd_vld_i,
    input  logic [3:0]                  rx_cmd_op_i,
    input  logic [3:0]                  rx_cmd_id_i,
    input  logic [DW-1:0]               rx_cmd_dt_i,
    input  logic                        auto_id_arm_i,
    input  logic                        ovf_clr_i,
    output logic                        qp_vld_o,
    output logic                        qp_flag_o,
    output logic [NREG*DW-1:0]          qp_dt_o,
    output logic [MEM_DEPTH*DW-1:0]     mem_o,
    output logic [3:0]                  board_id_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_lvl_o,
    output logic                        rx_ovf_o,
    output logic                        auto_id_busy_o,
    output logic                        auto_id_tmo_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 8 + DW;
    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

    typedef enum logic {IDLE, ARMED} aid_state_t;

    function automatic logic rx_pushable(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == 4'hA) || (op == 4'hB) ||
               (op == 4'hC) || (op == 4'hE);
    endfunction

    function automatic logic reg_in_range(input logic [3:0] idx);
        return {1'b0, idx} < 5'(NREG);
    endfunction

    function automatic logic mem_in_range(input logic [3:0] addr);
        return {1'b0, addr} < 5'(MEM_DEPTH);
    endfunction

    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          push, push_ok, pop, loc_exec;
    logic [3:0]    head_op, head_id;
    logic [DW-1:0] head_dt;

    logic [DW-1:0] reg_q [NREG];
    logic [DW-1:0] mem_q [MEM_DEPTH];

    logic          flag_we, flag_d;
    logic          reg_we, mem_we, bid_we;
    logic [3:0]    reg_idx, mem_addr, bid_d;
    logic [DW-1:0] wr_dt;
    logic          aid_reply, loc_bid;

    aid_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          tmo_d;

    assign loc_exec   = cmd_loc_req_i & ~cmd_loc_ack_o;
    assign fifo_full  = (fifo_cnt == LW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = ~loc_exec & ~fifo_empty;
    assign push       = rx_cmd_vld_i & rx_pushable(rx_cmd_op_i);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok    = push & (~fifo_full | pop);

    assign head_op = fifo_q[rd_ptr][EW-1 -: 4];
    assign head_id = fifo_q[rd_ptr][EW-5 -: 4];
    assign head_dt = fifo_q[rd_ptr][DW-1:0];

    assign fifo_lvl_o     = fifo_cnt;
    assign auto_id_busy_o = (state == ARMED);

    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            cmd_loc_ack_o <= 1'b0;
        end else if (loc_exec) begin
            cmd_loc_ack_o <= 1'b1;
        end else if (!cmd_loc_req_i) begin
            cmd_loc_ack_o <= 1'b0;
        end
    end

    // Entry storage needs no reset: the pointers define which words are live.
    always_ff @(posedge c_clk_i) begin
        if (push_ok) begin
            fifo_q[wr_ptr] <= {rx_cmd_op_i, rx_cmd_id_i, rx_cmd_dt_i};
        end
    end

    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rx_ovf_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && !push_ok) begin
                rx_ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                rx_ovf_o <= 1'b0;
            end
        end
    end

    always_comb begin
        flag_we   = 1'b0;
        flag_d    = 1'b0;
        reg_we    = 1'b0;
        reg_idx   = 4'd0;
        mem_we    = 1'b0;
        mem_addr  = 4'd0;
        bid_we    = 1'b0;
        bid_d     = 4'd0;
        wr_dt     = '0;
        aid_reply = 1'b0;
        loc_bid   = 1'b0;
        if (loc_exec) begin
            wr_dt = cmd_loc_dt_i;
            case (cmd_loc_op_i[7:4])
                4'h0: begin
                    bid_we  = 1'b1;
                    bid_d   = cmd_loc_op_i[3:0];
                    loc_bid = 1'b1;
                end
                4'h1: begin
                    flag_we = 1'b1;
                    flag_d  = cmd_loc_op_i[0];
                end
                4'h2: begin
                    reg_idx = cmd_loc_op_i[3:0];
                    reg_we  = reg_in_range(reg_idx);
                end
                4'h3: begin
                    mem_addr = cmd_loc_op_i[3:0];
                    mem_we   = mem_in_range(mem_addr);
                end
                default: ;
            endcase
        end else if (pop) begin
            wr_dt = head_dt;
            case (head_op)
                4'h0, 4'h1: begin
                    flag_we = 1'b1;
                    flag_d  = head_op[0];
                end
                // 001x/010x/011x map pairwise onto register indices 0..5.
                4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    reg_idx = {1'b0, head_op[2:1] - 2'd1, head_op[0]};
                    reg_we  = reg_in_range(reg_idx);
                end
                4'hA, 4'hC, 4'hE: begin
                    mem_addr = head_id + 4'd1;
                    mem_we   = mem_in_range(mem_addr);
                end
                4'hB: begin
                    aid_reply = (state == ARMED);
                    bid_we    = aid_reply;
                    bid_d     = head_id + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            qp_vld_o   <= 1'b0;
            qp_flag_o  <= 1'b0;
            board_id_o <= 4'd0;
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            qp_vld_o <= reg_we;
            if (flag_we) qp_flag_o <= flag_d;
            if (bid_we) board_id_o <= bid_d;
            for (int i = 0; i < NREG; i++) begin
                if (reg_we && reg_idx == 4'(i)) reg_q[i] <= wr_dt;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (mem_we && mem_addr == 4'(i)) mem_q[i] <= wr_dt;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign qp_dt_o[g*DW +: DW] = reg_q[g];
    end
    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_mem_out
        assign mem_o[g*DW +: DW] = mem_q[g];
    end

    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            auto_id_tmo_o <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            auto_id_tmo_o <= tmo_d;
        end
    end

    // Timeout fires on the edge TMO_CYC cycles after arming; a fresh arm always wins.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tmo_d   = 1'b0;
        case (state)
            IDLE: begin
                if (auto_id_arm_i) begin
                    state_d = ARMED;
                    cnt_d   = CW'(TMO_CYC);
                end
            end
            ARMED: begin
                if (auto_id_arm_i) begin
                    cnt_d = CW'(TMO_CYC);
                end else if (aid_reply || loc_bid) begin
                    state_d = IDLE;
                end else if (TMO_CYC != 0 && cnt == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qick_xcom_exec.sv
// Directed bench for qick_xcom_exec: handshake, arbitration, FIFO overflow, auto-ID, reset.
module tb_qick_xcom_exec;

    localparam int DW         = 32;
    localparam int NREG       = 2;
    localparam int MEM_DEPTH  = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int TMO_CYC    = 10;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        req = 1'b0;
    logic                        ack;
    logic [7:0]                  loc_op = '0;
    logic [DW-1:0]               loc_dt = '0;
    logic                        rx_vld = 1'b0;
    logic [3:0]                  rx_op = '0;
    logic [3:0]                  rx_id = '0;
    logic [DW-1:0]               rx_dt = '0;
    logic                        arm = 1'b0;
    logic                        ovf_clr = 1'b0;
    logic                        qp_vld, qp_flag;
    logic [NREG*DW-1:0]          qp_dt;
    logic [MEM_DEPTH*DW-1:0]     mem;
    logic [3:0]                  board_id;
    logic [$clog2(FIFO_DEPTH):0] lvl;
    logic                        ovf, busy, tmo;

    int n_chk  = 0;
    int n_pass = 0;
    int n_tmo;

    qick_xcom_exec #(
        .DW(DW), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH), .TMO_CYC(TMO_CYC)
    ) dut (
        .c_clk_i(clk), .c_rst_i(rst),
        .cmd_loc_req_i(req), .cmd_loc_ack_o(ack),
        .cmd_loc_op_i(loc_op), .cmd_loc_dt_i(loc_dt),
        .rx_cmd_vld_i(rx_vld), .rx_cmd_op_i(rx_op), .rx_cmd_id_i(rx_id), .rx_cmd_dt_i(rx_dt),
        .auto_id_arm_i(arm), .ovf_clr_i(ovf_clr),
        .qp_vld_o(qp_vld), .qp_flag_o(qp_flag), .qp_dt_o(qp_dt), .mem_o(mem),
        .board_id_o(board_id), .fifo_lvl_o(lvl), .rx_ovf_o(ovf),
        .auto_id_busy_o(busy), .auto_id_tmo_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] regw(input int i);
        return qp_dt[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] memw(input int a);
        return mem[a*DW +: DW];
    endfunction

    task automatic rx_send(input logic [3:0] op, input logic [3:0] id, input logic [DW-1:0] dt);
        rx_vld = 1'b1;
        rx_op  = op;
        rx_id  = id;
        rx_dt  = dt;
        tick();
        rx_vld = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_flag", qp_flag, 0);
        chk("rst_lvl", lvl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem", |mem, 0);
        rst = 1'b0;
        tick();

        // Local register write and full 4-phase handshake
        req = 1'b1; loc_op = 8'h21; loc_dt = 32'hDEADBEEF;
        tick();
        chk("loc_ack_rise", ack, 1);
        chk("loc_reg1", regw(1), 32'hDEADBEEF);
        chk("loc_qp_vld", qp_vld, 1);
        tick();
        chk("loc_ack_hold", ack, 1);
        chk("loc_qp_vld_once", qp_vld, 0);
        req = 1'b0;
        tick();
        chk("loc_ack_fall", ack, 0);

        // Local flag set, then a collision of local flag clear with an RX reg write
        req = 1'b1; loc_op = 8'h11;
        tick();
        chk("loc_flag_set", qp_flag, 1);
        req = 1'b0;
        tick();
        req = 1'b1; loc_op = 8'h10;
        rx_send(4'h3, 4'h0, 32'h12345678);
        chk("coll_flag", qp_flag, 0);
        chk("coll_lvl", lvl, 1);
        chk("coll_reg1_old", regw(1), 32'hDEADBEEF);
        tick();
        chk("coll_reg1_new", regw(1), 32'h12345678);
        chk("coll_qp_vld", qp_vld, 1);
        chk("coll_lvl_empty", lvl, 0);
        req = 1'b0;
        tick();

        // Nine RX memory writes back to back, local commands stalling every other pop
        loc_op = 8'h40;
        for (int i = 1; i <= 9; i++) begin
            req = (i % 2 == 1);
            rx_send(4'hA, 4'(i - 1), 32'h100 + i - 1);
            if (i == 8) chk("fifo_full_pushpop", lvl, 4);
        end
        req = 1'b0;
        chk("ovf_lvl", lvl, 4);
        chk("ovf_set", ovf, 1);
        chk("ovf_mem1", memw(1), 32'h100);
        repeat (4) tick();
        chk("drain_lvl", lvl, 0);
        chk("drain_mem8", memw(8), 32'h107);
        chk("drop_mem9", memw(9), 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);

        // Auto-ID reply
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("aid_busy", busy, 1);
        rx_send(4'hB, 4'h3, 32'h0);
        tick();
        chk("aid_bid", board_id, 4);
        chk("aid_idle", busy, 0);

        // Auto-ID timeout
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_tmo = 0;
        repeat (9) begin
            tick();
            if (tmo) n_tmo++;
        end
        chk("tmo_early", n_tmo, 0);
        chk("tmo_busy_pre", busy, 1);
        tick();
        chk("tmo_pulse", tmo, 1);
        chk("tmo_idle", busy, 0);
        tick();
        chk("tmo_pulse_end", tmo, 0);
        rx_send(4'hB, 4'h7, 32'h0);
        tick();
        chk("tmo_late_reply", board_id, 4);

        // Local board-ID write cancels an armed auto-ID without a timeout
        arm = 1'b1;
        tick();
        arm = 1'b0;
        req = 1'b1; loc_op = 8'h05;
        tick();
        chk("loc_bid", board_id, 5);
        chk("loc_bid_idle", busy, 0);
        req = 1'b0;
        n_tmo = 0;
        repeat (12) begin
            tick();
            if (tmo) n_tmo++;
        end
        chk("loc_bid_no_tmo", n_tmo, 0);

        // RX memory address wrap and out-of-range, filters and ignored registers
        rx_send(4'hA, 4'hF, 32'hCAFE0000);
        tick();
        chk("rx_mem0", memw(0), 32'hCAFE0000);
        rx_send(4'hC, 4'hE, 32'h00000BAD);
        tick();
        chk("rx_mem_oor_lvl", lvl, 0);
        chk("rx_mem_oor_mem0", memw(0), 32'hCAFE0000);
        chk("rx_mem_oor_mem14", memw(14), 0);
        rx_send(4'h8, 4'h0, 32'h1);
        chk("rx_filter", lvl, 0);
        rx_send(4'h1, 4'h0, 32'h0);
        tick();
        chk("rx_flag", qp_flag, 1);
        rx_send(4'h2, 4'h0, 32'hA5A5A5A5);
        tick();
        chk("rx_reg0", regw(0), 32'hA5A5A5A5);
        rx_send(4'h7, 4'h0, 32'h77777777);
        tick();
        chk("rx_reg5_vld", qp_vld, 0);
        chk("rx_reg5_reg1", regw(1), 32'h12345678);

        // Reset mid-burst with FIFO occupied, request held and auto-ID armed
        req = 1'b1; loc_op = 8'h40; arm = 1'b1;
        rx_send(4'hA, 4'h1, 32'h55);
        arm = 1'b0;
        chk("burst_lvl", lvl, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_lvl", lvl, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_bid", board_id, 0);
        chk("rst_mid_flag", qp_flag, 0);
        chk("rst_mid_qp", |qp_dt, 0);
        chk("rst_mid_mem", |mem, 0);
        req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_lvl", lvl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
